// File: rtl/lector_rom16x4.sv
// lector_rom16x4: sequential fetch unit in front of a 16x4 ROM built from four
// 4x4 chips. It presents an address, waits ESPERA cycles for the selected
// chip's output to settle, captures the nibble, and offers it downstream over
// a valid/ready handshake. Bursts of 1..16 reads, address wraps modulo 16.
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous active-high reset
//   inicio       burst start request (sampled only when idle)
//   dir_inicial  first ROM address of the burst
//   cantidad     burst length minus one
//   address      registered ROM address
//   datos        nibble returned by the ROM
//   dato         captured nibble, stable while valido=1
//   valido       dato holds an unaccepted nibble
//   listo        downstream ready
//   ocupado      burst in progress (decoded from state)
//   fin          one-cycle pulse after the last nibble is accepted
module lector_rom16x4 #(
  parameter int unsigned ESPERA = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inicio,
  input  logic [3:0] dir_inicial,
  input  logic [3:0] cantidad,
  output logic [3:0] address,
  input  logic [3:0] datos,
  output logic [3:0] dato,
  output logic       valido,
  input  logic       listo,
  output logic       ocupado,
  output logic       fin
);

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 4;
  localparam int unsigned EW = 3;

  localparam logic [1:0] INACTIVO   = 2'd0;
  localparam logic [1:0] DIRECCIONA = 2'd1;
  localparam logic [1:0] ENTREGA    = 2'd2;

  // Counter value loaded on every address change; capture happens when it hits 0.
  localparam logic [EW-1:0] ESPERA_RELOAD = EW'(ESPERA - 1);

  logic [1:0]    state_q,     state_d;
  logic [AW-1:0] address_q,   address_d;
  logic [AW-1:0] restantes_q, restantes_d;
  logic [EW-1:0] espera_q,    espera_d;
  logic [DW-1:0] dato_q,      dato_d;
  logic          valido_q,    valido_d;
  logic          fin_q,       fin_d;

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    address_d   = address_q;
    restantes_d = restantes_q;
    espera_d    = espera_q;
    dato_d      = dato_q;
    valido_d    = valido_q;
    fin_d       = 1'b0;

    case (state_q)
      INACTIVO: begin
        if (inicio) begin
          address_d   = dir_inicial;
          restantes_d = cantidad;
          espera_d    = ESPERA_RELOAD;
          state_d     = DIRECCIONA;
        end
      end

      DIRECCIONA: begin
        if (espera_q != '0) begin
          espera_d = espera_q - EW'(1);
        end else begin
          dato_d   = datos;
          valido_d = 1'b1;
          state_d  = ENTREGA;
        end
      end

      ENTREGA: begin
        if (listo) begin
          valido_d = 1'b0;
          if (restantes_q == '0) begin
            fin_d   = 1'b1;
            state_d = INACTIVO;
          end else begin
            // 4-bit add wraps 15 -> 0 naturally.
            address_d   = address_q + AW'(1);
            restantes_d = restantes_q - AW'(1);
            espera_d    = ESPERA_RELOAD;
            state_d     = DIRECCIONA;
          end
        end
      end

      default: begin
        state_d  = INACTIVO;
        valido_d = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INACTIVO;
      address_q   <= '0;
      restantes_q <= '0;
      espera_q    <= '0;
      dato_q      <= '0;
      valido_q    <= 1'b0;
      fin_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      address_q   <= address_d;
      restantes_q <= restantes_d;
      espera_q    <= espera_d;
      dato_q      <= dato_d;
      valido_q    <= valido_d;
      fin_q       <= fin_d;
    end
  end

  assign address = address_q;
  assign dato    = dato_q;
  assign valido  = valido_q;
  assign fin     = fin_q;
  assign ocupado = (state_q != INACTIVO);

endmodule

// File: tb/tb_lector_rom16x4.sv
// Directed bench for lector_rom16x4: one instance with ESPERA=1, one with
// ESPERA=3, each reading its own model of a ROM holding m[i] = ~i.
module tb_lector_rom16x4;

  logic       clk = 1'b0;
  logic       reset;
  logic       inicio1, inicio3;
  logic [3:0] dir_inicial, cantidad;
  logic       listo;

  logic [3:0] address1, datos1, dato1;
  logic       valido1, ocupado1, fin1;
  logic [3:0] address3, datos3, dato3;
  logic       valido3, ocupado3, fin3;

  logic [3:0] rom [16];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign datos1 = rom[address1];
  assign datos3 = rom[address3];

  lector_rom16x4 #(.ESPERA(1)) dut1 (
    .clk(clk), .reset(reset), .inicio(inicio1), .dir_inicial(dir_inicial),
    .cantidad(cantidad), .address(address1), .datos(datos1), .dato(dato1),
    .valido(valido1), .listo(listo), .ocupado(ocupado1), .fin(fin1)
  );

  lector_rom16x4 #(.ESPERA(3)) dut3 (
    .clk(clk), .reset(reset), .inicio(inicio3), .dir_inicial(dir_inicial),
    .cantidad(cantidad), .address(address3), .datos(datos3), .dato(dato3),
    .valido(valido3), .listo(listo), .ocupado(ocupado3), .fin(fin3)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_d [4];
  logic [3:0] exp_a [4];
  logic [3:0] sweep_d [16];
  logic [3:0] a;

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = ~4'(i);
    reset = 1'b1; inicio1 = 1'b0; inicio3 = 1'b0;
    dir_inicial = 4'd0; cantidad = 4'd0; listo = 1'b1;
    tick(); tick();

    // Reset state of both instances.
    chk("rst_address1", 8'(address1), 8'h0);
    chk("rst_dato1",    8'(dato1),    8'h0);
    chk("rst_valido1",  8'(valido1),  8'h0);
    chk("rst_ocupado1", 8'(ocupado1), 8'h0);
    chk("rst_fin1",     8'(fin1),     8'h0);
    chk("rst_address3", 8'(address3), 8'h0);
    chk("rst_ocupado3", 8'(ocupado3), 8'h0);
    reset = 1'b0;
    tick();

    // Basic burst: addresses 0..3 -> F,E,D,C, two cycles apart, fin at k+8.
    exp_d = '{4'hF, 4'hE, 4'hD, 4'hC};
    exp_a = '{4'h0, 4'h1, 4'h2, 4'h3};
    inicio1 = 1'b1; dir_inicial = 4'd0; cantidad = 4'd3;
    tick();
    inicio1 = 1'b0;
    chk("basic_start_addr", 8'(address1), 8'h0);
    chk("basic_start_ocup", 8'(ocupado1), 8'h1);
    chk("basic_start_val",  8'(valido1),  8'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("basic_valido", 8'(valido1), 8'h1);
      chk("basic_dato",   8'(dato1),   8'(exp_d[i]));
      chk("basic_addr",   8'(address1), 8'(exp_a[i]));
      chk("basic_datos_known", 8'($isunknown(datos1)), 8'h0);
      tick();
      chk("basic_valido_low", 8'(valido1), 8'h0);
      if (i < 3) begin
        chk("basic_fin_early", 8'(fin1), 8'h0);
        chk("basic_ocup_mid",  8'(ocupado1), 8'h1);
      end else begin
        chk("basic_fin",      8'(fin1),     8'h1);
        chk("basic_ocup_end", 8'(ocupado1), 8'h0);
      end
    end
    tick();
    chk("basic_fin_once", 8'(fin1),     8'h0);
    chk("basic_idle",     8'(ocupado1), 8'h0);

    // Wrap-around: 14,15,0,1 -> 1,0,F,E.
    exp_d = '{4'h1, 4'h0, 4'hF, 4'hE};
    exp_a = '{4'hE, 4'hF, 4'h0, 4'h1};
    inicio1 = 1'b1; dir_inicial = 4'd14; cantidad = 4'd3;
    tick();
    inicio1 = 1'b0;
    chk("wrap_start_addr", 8'(address1), 8'hE);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wrap_dato", 8'(dato1),    8'(exp_d[i]));
      chk("wrap_addr", 8'(address1), 8'(exp_a[i]));
      tick();
    end
    chk("wrap_fin", 8'(fin1), 8'h1);

    // Restart in the fin cycle: single read at address 2 with backpressure.
    inicio1 = 1'b1; dir_inicial = 4'd2; cantidad = 4'd0;
    tick();
    inicio1 = 1'b0;
    chk("finstart_ocup", 8'(ocupado1), 8'h1);
    chk("finstart_addr", 8'(address1), 8'h2);
    chk("finstart_fin",  8'(fin1),     8'h0);
    listo = 1'b0;
    tick();
    chk("bp_valido", 8'(valido1), 8'h1);
    chk("bp_dato",   8'(dato1),   8'hD);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valido", 8'(valido1),  8'h1);
      chk("bp_hold_dato",   8'(dato1),    8'hD);
      chk("bp_hold_addr",   8'(address1), 8'h2);
      chk("bp_hold_fin",    8'(fin1),     8'h0);
    end
    listo = 1'b1;
    tick();
    chk("bp_release_valido", 8'(valido1),  8'h0);
    chk("bp_release_fin",    8'(fin1),     8'h1);
    chk("bp_release_ocup",   8'(ocupado1), 8'h0);
    tick();
    chk("bp_fin_clear", 8'(fin1), 8'h0);

    // Ignored restart: inicio held through ENTREGA and DIRECCIONA.
    inicio1 = 1'b1; dir_inicial = 4'd0; cantidad = 4'd1;
    tick();
    tick();
    chk("ign_dato0", 8'(dato1), 8'hF);
    inicio1 = 1'b1; dir_inicial = 4'd9; cantidad = 4'd7;
    tick();
    chk("ign_addr1",  8'(address1), 8'h1);
    chk("ign_valido", 8'(valido1),  8'h0);
    tick();
    inicio1 = 1'b0;
    chk("ign_dato1", 8'(dato1),    8'hE);
    chk("ign_addr1b", 8'(address1), 8'h1);
    tick();
    chk("ign_fin",  8'(fin1),     8'h1);
    chk("ign_ocup", 8'(ocupado1), 8'h0);
    tick();

    // Reset during ENTREGA aborts without fin.
    inicio1 = 1'b1; dir_inicial = 4'd3; cantidad = 4'd5;
    tick();
    inicio1 = 1'b0;
    tick();
    chk("rstmid_pre_dato", 8'(dato1), 8'hC);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_addr",   8'(address1), 8'h0);
    chk("rstmid_dato",   8'(dato1),    8'h0);
    chk("rstmid_valido", 8'(valido1),  8'h0);
    chk("rstmid_ocup",   8'(ocupado1), 8'h0);
    chk("rstmid_fin",    8'(fin1),     8'h0);
    tick();
    chk("rstmid_nofin", 8'(fin1), 8'h0);
    inicio1 = 1'b1; dir_inicial = 4'd7; cantidad = 4'd0;
    tick();
    inicio1 = 1'b0;
    chk("post_rst_addr", 8'(address1), 8'h7);
    tick();
    chk("post_rst_dato", 8'(dato1), 8'h8);
    tick();
    chk("post_rst_fin", 8'(fin1), 8'h1);

    // Full sweep on ESPERA=3: 16 reads from 5, spacing 4, fin at k+64, ends at 4.
    sweep_d = '{4'hA, 4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3,
                4'h2, 4'h1, 4'h0, 4'hF, 4'hE, 4'hD, 4'hC, 4'hB};
    inicio3 = 1'b1; dir_inicial = 4'd5; cantidad = 4'd15;
    tick();
    inicio3 = 1'b0;
    chk("sweep_start_addr", 8'(address3), 8'h5);
    chk("sweep_start_ocup", 8'(ocupado3), 8'h1);
    a = 4'd5;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("sweep_wait1", 8'(valido3), 8'h0);
      tick();
      chk("sweep_wait2", 8'(valido3), 8'h0);
      tick();
      chk("sweep_valido", 8'(valido3),  8'h1);
      chk("sweep_dato",   8'(dato3),    8'(sweep_d[i]));
      chk("sweep_addr",   8'(address3), 8'(a));
      chk("sweep_datos_known", 8'($isunknown(datos3)), 8'h0);
      tick();
      chk("sweep_fin", 8'(fin3), (i == 15) ? 8'h1 : 8'h0);
      a = a + 4'd1;
    end
    chk("sweep_end_addr", 8'(address3), 8'h4);
    chk("sweep_end_ocup", 8'(ocupado3), 8'h0);
    tick();
    chk("sweep_fin_clear", 8'(fin3), 8'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lector_rom16x4.md
# lector_rom16x4

Sequential fetch unit placed directly upstream of the 16x4 ROM. It drives the ROM address, waits a programmable settle time for the selected 4x4 chip's tri-state output, captures the nibble, and hands it downstream over a valid/ready handshake. It performs bursts of 1–16 consecutive reads, with the address wrapping modulo 16.

## Interface
- `ESPERA`, default 1: settle cycles between an address change and data capture; legal range 1–7.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `inicio` in 1: start-of-burst request; sampled only in INACTIVO.
- `dir_inicial` in 4: first ROM address of the burst; sampled with `inicio`.
- `cantidad` in 4: burst length minus one (0 → 1 read, 15 → 16 reads); sampled with `inicio`.
- `address` out 4: registered address to the ROM.
- `datos` in 4: nibble returned by the ROM.
- `dato` out 4: captured nibble; stable while `valido`=1.
- `valido` out 1: `dato` holds a nibble not yet accepted.
- `listo` in 1: downstream accepts `dato` when `valido`=1 and `listo`=1 at a rising edge.
- `ocupado` out 1: burst in progress (state ≠ INACTIVO).
- `fin` out 1: one-cycle pulse after the last nibble of a burst is accepted.

## Operation
- States: INACTIVO, DIRECCIONA, ENTREGA.
- INACTIVO:
  - `inicio`=1 → `address`←`dir_inicial`, `restantes`←`cantidad`, `espera`←ESPERA−1, go to DIRECCIONA.
  - Otherwise hold.
- DIRECCIONA:
  - `espera`≠0 → decrement `espera`.
  - `espera`=0 → `dato`←`datos`, `valido`←1, go to ENTREGA.
- ENTREGA, `listo`=0: hold `dato`, `valido`, `address`.
- ENTREGA, `listo`=1 and `restantes`=0: `valido`←0, `fin`←1, go to INACTIVO.
- ENTREGA, `listo`=1 and `restantes`≠0: `valido`←0, `address`←`address`+1 (mod 16, 15→0), decrement `restantes`, reload `espera`, go to DIRECCIONA.
- `inicio`, `dir_inicial` and `cantidad` are ignored while `ocupado`=1.
- `fin` is high only during the first INACTIVO cycle after a burst. `inicio` asserted in that same cycle is accepted normally.
- `datos` is captured verbatim. Because the ROM's decoder always enables exactly one chip, `datos` is never z at capture; the bench asserts this.

## Timing
- Reset, at the edge where `reset`=1, sets: `address`=0, `dato`=0, `valido`=0, `ocupado`=0, `fin`=0, state INACTIVO, internal counters 0.
- Reset has priority over all other inputs. Mid-burst it aborts immediately with no `fin` pulse.
- `inicio` seen at edge k:
  - `address` valid from k.
  - `valido`=1 and `dato` loaded at edge k+ESPERA.
- Nibble-to-nibble spacing with `listo` held at 1: ESPERA+1 cycles. For ESPERA=1 that is one nibble every 2 cycles.
- Burst of N nibbles, `listo`=1 throughout: `fin` rises at edge k+N·(ESPERA+1).
- `ocupado` is a decode of the registered state; it rises at edge k and falls together with the `fin` rise.
- All outputs are registered or decoded from registered state. There is no combinational path from `listo` or `datos` to any output.

## Test plan
- Basic burst:
  - ROM content m[i]=~i; ESPERA=1, `listo`=1; `inicio` with `dir_inicial`=0, `cantidad`=3.
  - Required: `dato` = F, E, D, C on successive `valido` cycles, 2 cycles apart.
  - Required: `fin` pulses once, 8 cycles after `inicio`; `ocupado` low afterwards.
- Wrap-around: `dir_inicial`=14, `cantidad`=3 → `address` sequence 14, 15, 0, 1; `dato` = 1, 0, F, E.
- Backpressure: hold `listo`=0 for 5 cycles while `valido`=1 → `valido`, `dato` and `address` unchanged. The transfer completes on the first edge with `listo`=1.
- Ignored restart:
  - Pulse `inicio` mid-burst with a different `dir_inicial` and `cantidad` → the burst continues unaffected.
  - `inicio` in the `fin` cycle → a new burst starts at the next edge.
- Reset mid-burst: assert `reset` during ENTREGA → the next edge shows all outputs 0 and no `fin`; the following `inicio` works normally.
- Full sweep: ESPERA=3, `dir_inicial`=5, `cantidad`=15 → 16 reads covering all four ROM chips, ending at `address`=4; spacing 4 cycles; `fin` at edge k+64.
